// File: rtl/sram_array_1r1w_init_if.sv
// rtl/sram_array_1r1w_init_if.sv - read/write port bundle for sram_array_1r1w_init
interface sram_array_1r1w_init_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 7,
  parameter int MASK_WIDTH = 8
);
  logic                  ready;
  logic                  r_en;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  w_en;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [MASK_WIDTH-1:0] w_mask;
  logic [DATA_WIDTH-1:0] w_data;

  modport master (
    input  ready, r_valid, r_data,
    output r_en, r_addr, w_en, w_addr, w_mask, w_data
  );

  modport slave (
    output ready, r_valid, r_data,
    input  r_en, r_addr, w_en, w_addr, w_mask, w_data
  );
endinterface

// File: rtl/sram_array_1r1w_init.sv
// rtl/sram_array_1r1w_init.sv - 1R1W masked SRAM array with hardware clear after reset
module sram_array_1r1w_init #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 128,
  parameter int ADDR_WIDTH = 7,
  parameter int MASK_WIDTH = 8,
  parameter bit BYPASS     = 1'b1,
  parameter bit HOLD_READ  = 1'b1
) (
  input logic                   clock,
  input logic                   reset,
  sram_array_1r1w_init_if.slave bus
);
  localparam int GRAN = DATA_WIDTH / MASK_WIDTH;
  localparam logic [ADDR_WIDTH:0]   DEPTH_X = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST    = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {S_CLEAR, S_IDLE} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic                  r_valid_q, r_valid_d;
  logic [DATA_WIDTH-1:0] r_data_q, r_data_d;

  logic                  clear_en;
  logic                  ready;
  logic [DATA_WIDTH-1:0] bit_mask;
  logic [DATA_WIDTH-1:0] w_merged;
  logic [DATA_WIDTH-1:0] r_raw;
  logic                  r_in_range, w_in_range;
  logic                  rd_acc, wr_acc, collide;

  // FSM state and clear counter; reset restarts the clear from entry 0
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Walk the counter across every entry once, then settle in IDLE for good
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == S_CLEAR) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == LAST) begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    end
  end

  // FSM outputs: clear write strobe and port-usable flag
  always_comb begin
    clear_en = (state_q == S_CLEAR);
    ready    = (state_q == S_IDLE);
  end

  // Expand granule enables into a per-bit mask
  always_comb begin
    bit_mask = '0;
    for (int g = 0; g < MASK_WIDTH; g++) begin
      bit_mask[g*GRAN +: GRAN] = {GRAN{bus.w_mask[g]}};
    end
  end

  // Out-of-range addresses only exist for non-power-of-two depths
  assign r_in_range = ({1'b0, bus.r_addr} < DEPTH_X);
  assign w_in_range = ({1'b0, bus.w_addr} < DEPTH_X);
  assign rd_acc     = ready & bus.r_en;
  assign wr_acc     = ready & bus.w_en & w_in_range;
  assign w_merged   = (mem_q[bus.w_addr] & ~bit_mask) | (bus.w_data & bit_mask);
  assign collide    = BYPASS && wr_acc && (bus.w_addr == bus.r_addr);
  assign r_raw      = !r_in_range ? '0 : (collide ? w_merged : mem_q[bus.r_addr]);

  // Array storage: clear walk has priority, user writes only once ready
  always_ff @(posedge clock) begin
    if (clear_en) begin
      mem_q[cnt_q] <= '0;
    end else if (wr_acc) begin
      mem_q[bus.w_addr] <= w_merged;
    end
  end

  // Read result next-state: new data on a read, otherwise hold or zero
  always_comb begin
    r_valid_d = rd_acc;
    if (rd_acc) begin
      r_data_d = r_raw;
    end else if (HOLD_READ) begin
      r_data_d = r_data_q;
    end else begin
      r_data_d = '0;
    end
  end

  // Read output register, one-cycle latency
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_valid_q <= 1'b0;
      r_data_q  <= '0;
    end else begin
      r_valid_q <= r_valid_d;
      r_data_q  <= r_data_d;
    end
  end

  assign bus.ready   = ready;
  assign bus.r_valid = r_valid_q;
  assign bus.r_data  = r_data_q;
endmodule

// File: tb/tb_sram_array_1r1w_init.sv
// tb/tb_sram_array_1r1w_init.sv - self-checking bench for sram_array_1r1w_init
module tb_sram_array_1r1w_init;
  localparam int DW = 32;
  localparam int DEPTH = 128;
  localparam int AW = 7;
  localparam int MW = 4;
  localparam int GB = DW / MW;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  sram_array_1r1w_init_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MASK_WIDTH(MW)) bus_a ();
  sram_array_1r1w_init_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MASK_WIDTH(MW)) bus_b ();

  assign bus_b.r_en   = bus_a.r_en;
  assign bus_b.r_addr = bus_a.r_addr;
  assign bus_b.w_en   = bus_a.w_en;
  assign bus_b.w_addr = bus_a.w_addr;
  assign bus_b.w_mask = bus_a.w_mask;
  assign bus_b.w_data = bus_a.w_data;

  // a: bypass + hold, b: no bypass + zero-when-idle
  sram_array_1r1w_init #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .MASK_WIDTH(MW),
                         .BYPASS(1'b1), .HOLD_READ(1'b1))
    u_dut_a (.clock(clock), .reset(reset), .bus(bus_a));
  sram_array_1r1w_init #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .MASK_WIDTH(MW),
                         .BYPASS(1'b0), .HOLD_READ(1'b0))
    u_dut_b (.clock(clock), .reset(reset), .bus(bus_b));

  logic [DW-1:0] model [DEPTH];
  logic [DW-1:0] exp_a, exp_b;
  logic          exp_v;
  int n_cmp = 0;
  int n_bad = 0;

  task automatic reset_model();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    exp_a = '0;
    exp_b = '0;
    exp_v = 1'b0;
  endtask

  // One IDLE cycle of stimulus; updates the model and the expected outputs
  task automatic step(input logic re, input logic [AW-1:0] ra, input logic we,
                      input logic [AW-1:0] wa, input logic [MW-1:0] wm, input logic [DW-1:0] wd);
    logic [DW-1:0] pre, post;
    bus_a.r_en = re; bus_a.r_addr = ra;
    bus_a.w_en = we; bus_a.w_addr = wa; bus_a.w_mask = wm; bus_a.w_data = wd;
    pre = model[ra];
    if (we) begin
      for (int g = 0; g < MW; g++)
        if (wm[g]) model[wa][g*GB +: GB] = wd[g*GB +: GB];
    end
    post = model[ra];
    exp_v = re;
    if (re) begin
      exp_a = post;
      exp_b = pre;
    end else begin
      exp_b = '0;
    end
    @(posedge clock); #1;
    bus_a.r_en = 1'b0;
    bus_a.w_en = 1'b0;
  endtask

  task automatic release_and_count(output int cyc);
    @(negedge clock);
    reset = 1'b0;
    cyc = 0;
    while (!bus_a.ready && cyc < 400) begin
      @(posedge clock); #1;
      cyc++;
    end
    reset_model();
  endtask

  task automatic test_reset();
    int cyc;
    @(posedge clock); #1;
    n_cmp++; if (bus_a.ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready: got %b want 0", bus_a.ready); end
    n_cmp++; if (bus_a.r_valid !== 1'b0) begin n_bad++; $display("FAIL rst_rvalid: got %b want 0", bus_a.r_valid); end
    n_cmp++; if (bus_a.r_data !== '0 || bus_b.r_data !== '0) begin n_bad++; $display("FAIL rst_rdata: got %h/%h want 0", bus_a.r_data, bus_b.r_data); end
    repeat (2) @(posedge clock);
    release_and_count(cyc);
    n_cmp++; if (cyc !== DEPTH) begin n_bad++; $display("FAIL clear_cycles: got %0d want %0d", cyc, DEPTH); end
    for (int a = 0; a < DEPTH; a++) begin
      step(1'b1, AW'(a), 1'b0, '0, '0, '0);
      n_cmp++; if (bus_a.r_valid !== 1'b1 || bus_b.r_valid !== 1'b1) begin n_bad++; $display("FAIL clear_rvalid[%0d]: got %b/%b want 1", a, bus_a.r_valid, bus_b.r_valid); end
      n_cmp++; if (bus_a.r_data !== '0 || bus_b.r_data !== '0) begin n_bad++; $display("FAIL clear_rdata[%0d]: got %h/%h want 0", a, bus_a.r_data, bus_b.r_data); end
    end
  endtask

  task automatic test_masked_write();
    step(1'b0, '0, 1'b1, 7'd5, 4'hF, 32'hAABBCCDD);
    step(1'b0, '0, 1'b1, 7'd5, 4'h5, 32'h11223344);
    step(1'b1, 7'd5, 1'b0, '0, '0, '0);
    n_cmp++; if (bus_a.r_data !== 32'hAA22CC44 || bus_b.r_data !== 32'hAA22CC44) begin n_bad++; $display("FAIL masked_write: got %h/%h want aa22cc44", bus_a.r_data, bus_b.r_data); end
    step(1'b0, '0, 1'b1, 7'd6, 4'h0, 32'hFFFFFFFF);
    step(1'b1, 7'd6, 1'b0, '0, '0, '0);
    n_cmp++; if (bus_a.r_data !== 32'h0) begin n_bad++; $display("FAIL zero_mask_write: got %h want 0", bus_a.r_data); end
  endtask

  task automatic test_collision();
    step(1'b0, '0, 1'b1, 7'd9, 4'hF, 32'h0000FFFF);
    step(1'b1, 7'd9, 1'b1, 7'd9, 4'hC, 32'h12345678);
    n_cmp++; if (bus_a.r_data !== 32'h1234FFFF) begin n_bad++; $display("FAIL collide_bypass: got %h want 1234ffff", bus_a.r_data); end
    n_cmp++; if (bus_b.r_data !== 32'h0000FFFF) begin n_bad++; $display("FAIL collide_nobypass: got %h want 0000ffff", bus_b.r_data); end
    step(1'b1, 7'd9, 1'b0, '0, '0, '0);
    n_cmp++; if (bus_b.r_data !== 32'h1234FFFF) begin n_bad++; $display("FAIL collide_after: got %h want 1234ffff", bus_b.r_data); end
  endtask

  task automatic test_read_hold();
    step(1'b0, '0, 1'b1, 7'd3, 4'hF, 32'h7E);
    step(1'b1, 7'd3, 1'b0, '0, '0, '0);
    n_cmp++; if (bus_a.r_data !== 32'h7E || bus_b.r_data !== 32'h7E) begin n_bad++; $display("FAIL hold_first: got %h/%h want 7e", bus_a.r_data, bus_b.r_data); end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, '0, 1'b0, '0, '0, '0);
      n_cmp++; if (bus_a.r_valid !== 1'b0 || bus_b.r_valid !== 1'b0) begin n_bad++; $display("FAIL hold_rvalid[%0d]: got %b/%b want 0", i, bus_a.r_valid, bus_b.r_valid); end
      n_cmp++; if (bus_a.r_data !== 32'h7E) begin n_bad++; $display("FAIL hold_a[%0d]: got %h want 7e", i, bus_a.r_data); end
      n_cmp++; if (bus_b.r_data !== 32'h0) begin n_bad++; $display("FAIL hold_b[%0d]: got %h want 0", i, bus_b.r_data); end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1, AW'(20 + i), 4'hF, $urandom);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, AW'(20 + i), 1'b1, AW'(27 - i), 4'(i), $urandom);
      n_cmp++; if (bus_a.r_valid !== 1'b1 || bus_a.r_data !== exp_a || bus_b.r_data !== exp_b) begin
        n_bad++; $display("FAIL b2b[%0d]: got %b %h/%h want 1 %h/%h", i, bus_a.r_valid, bus_a.r_data, bus_b.r_data, exp_a, exp_b);
      end
    end
  endtask

  task automatic test_random();
    logic re, we;
    logic [AW-1:0] ra, wa;
    for (int i = 0; i < 400; i++) begin
      re = 1'($urandom_range(0, 1));
      we = 1'($urandom_range(0, 1));
      ra = AW'($urandom_range(0, 15));
      wa = AW'($urandom_range(0, 15));
      step(re, ra, we, wa, 4'($urandom_range(0, 15)), $urandom);
      n_cmp++; if (bus_a.r_valid !== exp_v || bus_b.r_valid !== exp_v) begin n_bad++; $display("FAIL rand_valid[%0d]: got %b/%b want %b", i, bus_a.r_valid, bus_b.r_valid, exp_v); end
      n_cmp++; if (bus_a.r_data !== exp_a) begin n_bad++; $display("FAIL rand_data_a[%0d]: got %h want %h", i, bus_a.r_data, exp_a); end
      n_cmp++; if (bus_b.r_data !== exp_b) begin n_bad++; $display("FAIL rand_data_b[%0d]: got %h want %h", i, bus_b.r_data, exp_b); end
    end
  endtask

  task automatic test_reset_mid_clear();
    int cyc;
    step(1'b0, '0, 1'b1, 7'd100, 4'hF, 32'h5A);
    step(1'b1, 7'd100, 1'b0, '0, '0, '0);
    n_cmp++; if (bus_a.r_data !== 32'h5A) begin n_bad++; $display("FAIL midclr_pre: got %h want 5a", bus_a.r_data); end
    reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    repeat (60) @(posedge clock);
    #1;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    release_and_count(cyc);
    n_cmp++; if (cyc !== DEPTH) begin n_bad++; $display("FAIL midclr_cycles: got %0d want %0d", cyc, DEPTH); end
    step(1'b1, 7'd100, 1'b0, '0, '0, '0);
    n_cmp++; if (bus_a.r_data !== 32'h0 || bus_a.r_valid !== 1'b1) begin n_bad++; $display("FAIL midclr_entry100: got %b %h want 1 0", bus_a.r_valid, bus_a.r_data); end
  endtask

  task automatic test_ignore_during_clear();
    int cyc;
    bit saw_valid;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    cyc = 0;
    saw_valid = 1'b0;
    while (!bus_a.ready && cyc < 400) begin
      if (cyc == 10) begin
        bus_a.r_en = 1'b1; bus_a.r_addr = 7'd2;
        bus_a.w_en = 1'b1; bus_a.w_addr = 7'd2; bus_a.w_mask = 4'hF; bus_a.w_data = 32'hFF;
      end
      @(posedge clock); #1;
      cyc++;
      bus_a.r_en = 1'b0;
      bus_a.w_en = 1'b0;
      if (bus_a.r_valid || bus_b.r_valid) saw_valid = 1'b1;
    end
    reset_model();
    n_cmp++; if (saw_valid !== 1'b0) begin n_bad++; $display("FAIL clr_rvalid: got %b want 0", saw_valid); end
    n_cmp++; if (cyc !== DEPTH) begin n_bad++; $display("FAIL clr_ign_cycles: got %0d want %0d", cyc, DEPTH); end
    step(1'b1, 7'd2, 1'b0, '0, '0, '0);
    n_cmp++; if (bus_a.r_data !== 32'h0 || bus_b.r_data !== 32'h0) begin n_bad++; $display("FAIL clr_addr2: got %h/%h want 0", bus_a.r_data, bus_b.r_data); end
  endtask

  initial begin
    bus_a.r_en = 1'b0; bus_a.r_addr = '0;
    bus_a.w_en = 1'b0; bus_a.w_addr = '0; bus_a.w_mask = '0; bus_a.w_data = '0;
    reset_model();
    test_reset();
    test_masked_write();
    test_collision();
    test_read_hold();
    test_back_to_back();
    test_random();
    test_reset_mid_clear();
    test_ignore_during_clear();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
